// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: instruction
// field encodings, the ALU operation codes, FSM states and instruction classes.
package mips_multicycle_control_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Register-file destination select
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // ALU operation codes; must match the ALU's own encoding exactly
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_OR   = 5'd2,
    ALU_ORI  = 5'd3,
    ALU_SRL  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_LUI  = 5'd6,
    ALU_ANDI = 5'd7,
    ALU_BEQ  = 5'd10,
    ALU_BNE  = 5'd11,
    ALU_NOR  = 5'd12,
    ALU_AND  = 5'd13,
    ALU_JMP  = 5'd14,
    ALU_JAL  = 5'd15,
    ALU_JR   = 5'd16
  } alu_op_e;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  // Instruction classes steering the EXEC/MEM/WB sequence
  typedef enum logic [2:0] {
    CL_ALU_R  = 3'd0,
    CL_ALU_I  = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_JUMP   = 3'd5,
    CL_JAL    = 3'd6,
    CL_JR     = 3'd7
  } instr_class_e;

  // Decoder result bundle
  typedef struct packed {
    alu_op_e      alu_op;
    instr_class_e iclass;
    logic         use_imm;
    logic         illegal;
  } decode_t;

endpackage

// File: rtl/mips_multicycle_control_instr_decoder.sv
// Combinational instruction decoder: opcode/funct -> ALU op, class,
// immediate-operand select and an illegal-encoding flag.
module mips_multicycle_control_instr_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output decode_t    o_dec
);

  // Decode table; anything not listed is reported as illegal
  always_comb begin
    o_dec.alu_op  = ALU_ADD;
    o_dec.iclass  = CL_ALU_R;
    o_dec.use_imm = 1'b0;
    o_dec.illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_dec.alu_op = ALU_ADD;
          FN_SUB:  o_dec.alu_op = ALU_SUB;
          FN_AND:  o_dec.alu_op = ALU_AND;
          FN_OR:   o_dec.alu_op = ALU_OR;
          FN_NOR:  o_dec.alu_op = ALU_NOR;
          FN_SLL:  o_dec.alu_op = ALU_SLL;
          FN_SRL:  o_dec.alu_op = ALU_SRL;
          FN_JR: begin
            o_dec.alu_op = ALU_JR;
            o_dec.iclass = CL_JR;
          end
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.iclass  = CL_ALU_I;
        o_dec.use_imm = 1'b1;
      end
      OP_ANDI: begin
        o_dec.alu_op  = ALU_ANDI;
        o_dec.iclass  = CL_ALU_I;
        o_dec.use_imm = 1'b1;
      end
      OP_ORI: begin
        o_dec.alu_op  = ALU_ORI;
        o_dec.iclass  = CL_ALU_I;
        o_dec.use_imm = 1'b1;
      end
      OP_LUI: begin
        o_dec.alu_op  = ALU_LUI;
        o_dec.iclass  = CL_ALU_I;
        o_dec.use_imm = 1'b1;
      end
      OP_LW: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.iclass  = CL_LOAD;
        o_dec.use_imm = 1'b1;
      end
      OP_SW: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.iclass  = CL_STORE;
        o_dec.use_imm = 1'b1;
      end
      OP_BEQ: begin
        o_dec.alu_op = ALU_BEQ;
        o_dec.iclass = CL_BRANCH;
      end
      OP_BNE: begin
        o_dec.alu_op = ALU_BNE;
        o_dec.iclass = CL_BRANCH;
      end
      OP_J: begin
        o_dec.alu_op = ALU_JMP;
        o_dec.iclass = CL_JUMP;
      end
      OP_JAL: begin
        o_dec.alu_op = ALU_JAL;
        o_dec.iclass = CL_JAL;
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// the datapath strobes and issues the ALU operation code.
//
// Memory handshake: mem_read_o/mem_write_o is a request that is raised in
// FETCH or MEM and held stable until the rising edge at which mem_ready_i is
// high (the access completes at that edge). If mem_ready_i stays low for
// MEM_WAIT_MAX cycles the request is withdrawn, bus_error_o pulses for one
// cycle and the FSM restarts at FETCH without writing PC or registers.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic [4:0] alu_operation_o,
  output logic       alu_src_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic [1:0] reg_dst_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_error_o,
  output logic [2:0] dbg_state_o
);

  // The wait counter saturates at 255, so larger limits clamp to 255
  localparam bit         TIMEOUT_EN = (MEM_WAIT_MAX != 0);
  localparam logic [7:0] WAIT_LIMIT = (MEM_WAIT_MAX > 255) ? 8'hFF : 8'(MEM_WAIT_MAX);

  state_e       r_state;
  state_e       w_next_state;
  alu_op_e      r_alu_op;
  instr_class_e r_class;
  logic         r_use_imm;
  logic [7:0]   r_wait_cnt;
  decode_t      w_dec;
  logic         w_mem_phase;
  logic         w_waiting;
  logic         w_timeout;

  mips_multicycle_control_instr_decoder u_decoder (
    .i_opcode (opcode_i),
    .i_funct  (funct_i),
    .o_dec    (w_dec)
  );

  assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_waiting   = w_mem_phase && !mem_ready_i;
  // Abort depends only on the counter, so the abort cycle is a clean Moore state
  assign w_timeout   = TIMEOUT_EN && w_mem_phase && (r_wait_cnt == WAIT_LIMIT);
  assign dbg_state_o = r_state;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RST;
    else        r_state <= w_next_state;
  end

  // Latch the decoded instruction for use from EXEC onward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_op  <= ALU_ADD;
      r_class   <= CL_ALU_R;
      r_use_imm <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_alu_op  <= w_dec.alu_op;
      r_class   <= w_dec.iclass;
      r_use_imm <= w_dec.use_imm;
    end
  end

  // Memory wait counter: counts not-ready cycles, clears on any state change or abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
    end else if ((w_next_state != r_state) || w_timeout) begin
      r_wait_cnt <= 8'd0;
    end else if (w_waiting && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next_state    = r_state;
    alu_operation_o = ALU_ADD;
    alu_src_o       = 1'b0;
    pc_write_o      = 1'b0;
    pc_src_o        = 1'b0;
    ir_write_o      = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = DST_RT;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    bus_error_o     = 1'b0;
    case (r_state)
      ST_RST: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_timeout) begin
          bus_error_o = 1'b1;
        end else begin
          mem_read_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o   = 1'b1;
            pc_write_o   = 1'b1;
            w_next_state = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        // PC already advanced in FETCH, so an illegal encoding just refetches
        if (w_dec.illegal) begin
          illegal_o    = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_operation_o = r_alu_op;
        alu_src_o       = r_use_imm;
        case (r_class)
          CL_BRANCH, CL_JUMP, CL_JR: begin
            // Not-taken branches get PC+4 back through the ALU pass-through
            pc_write_o   = 1'b1;
            pc_src_o     = 1'b1;
            instr_done_o = 1'b1;
            w_next_state = ST_FETCH;
          end
          CL_JAL: begin
            pc_write_o   = 1'b1;
            pc_src_o     = 1'b1;
            reg_write_o  = 1'b1;
            reg_dst_o    = DST_RA;
            instr_done_o = 1'b1;
            w_next_state = ST_FETCH;
          end
          CL_LOAD, CL_STORE: w_next_state = ST_MEM;
          default:           w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_operation_o = r_alu_op;
        alu_src_o       = r_use_imm;
        iord_o          = 1'b1;
        if (w_timeout) begin
          bus_error_o  = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          mem_read_o  = (r_class == CL_LOAD);
          mem_write_o = (r_class == CL_STORE);
          if (mem_ready_i) begin
            if (r_class == CL_LOAD) begin
              w_next_state = ST_WB;
            end else begin
              instr_done_o = 1'b1;
              w_next_state = ST_FETCH;
            end
          end
        end
      end
      ST_WB: begin
        alu_operation_o = r_alu_op;
        alu_src_o       = r_use_imm;
        reg_write_o     = 1'b1;
        reg_dst_o       = (r_class == CL_ALU_R) ? DST_RD : DST_RT;
        mem_to_reg_o    = (r_class == CL_LOAD);
        instr_done_o    = 1'b1;
        w_next_state    = ST_FETCH;
      end
      default: begin
        w_next_state = ST_RST;
      end
    endcase
  end

endmodule
